pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h00003000, fetch address after reset.
REQ-002 Parameter EXC_ENTRY, default 32'h00004180, exception/interrupt handler entry.
REQ-003 Parameter IMEM_LO, default 32'h00003000, lowest legal fetch address.
REQ-004 Parameter IMEM_HI, default 32'h00006FFC, highest legal fetch address.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 pc  input  32  current fetch address from the PC register.
REQ-008 stall  input  1  hazard unit freeze request for IF/ID.
REQ-009 br_taken  input  1  branch resolved taken in ID.
REQ-010 br_target  input  32  branch target.
REQ-011 jmp  input  1  jump (j/jal/jr/jalr) in ID.
REQ-012 jmp_target  input  32  jump target.
REQ-013 exc_req  input  1  CP0 exception/interrupt acceptance.
REQ-014 eret  input  1  eret committed.
REQ-015 epc  input  32  CP0 EPC value.
REQ-016 npc  output  32  next PC value to the PC register.
REQ-017 pc_en  output  1  PC register write enable.
REQ-018 flush  output  1  flush IF/ID (and younger stages) this cycle.
REQ-019 fetch_adel  output  1  fetch address error flag for current pc.
REQ-020 pend  output  1  a redirect is latched and waiting.

Function
REQ-021 Two states: RUN, PEND; 32-bit pend_target register.
REQ-022 Priority per cycle (highest first): reset, exc_req, eret, pending/new redirect, stall, sequential.
REQ-023 exc_req=1: npc=EXC_ENTRY, pc_en=1, flush=1, regardless of stall or state; next state RUN, pending target discarded.
REQ-024 eret=1 and exc_req=0: npc=epc, pc_en=1, flush=1, regardless of stall; next state RUN.
REQ-025 RUN, stall=0, jmp=1: npc=jmp_target, pc_en=1 (jmp beats br_taken if both asserted).
REQ-026 RUN, stall=0, br_taken=1, jmp=0: npc=br_target, pc_en=1.
REQ-027 RUN, stall=1, jmp or br_taken: pc_en=0, npc=pc, latch selected target into pend_target, next state PEND.
REQ-028 RUN, stall=1, no redirect: pc_en=0, npc=pc.
REQ-029 RUN, stall=0, no redirect: npc=pc+4 (unsigned 32-bit, wraps modulo 2^32), pc_en=1.
REQ-030 PEND, stall=1: pc_en=0, npc=pc; new br_taken/jmp ignored; pend_target held.
REQ-031 PEND, stall=0: npc=pend_target, pc_en=1; next state RUN; br_taken/jmp this cycle ignored.
REQ-032 npc, pc_en, flush, fetch_adel combinational from inputs and state; pend = (state==PEND), registered.
REQ-033 fetch_adel=1 iff pc[1:0]!=0, or pc<IMEM_LO, or pc>IMEM_HI (unsigned compares); purely a flag, no effect on sequencing.
REQ-034 flush=0 in all cases other than REQ-023/REQ-024.

Reset
REQ-035 reset=1 on a rising edge: state RUN, pend_target=0; all other inputs ignored.
REQ-036 While reset=1: npc=RESET_PC, pc_en=1, flush=0, pend=0 (after first edge); fetch_adel still reflects pc.
REQ-037 reset asserted in PEND discards the pending target; no redirect after reset release.

Verification
REQ-038 Reset, then 3 idle cycles, pc=32'h3000 -> npc=32'h3004, pc_en=1, flush=0, fetch_adel=0.
REQ-039 RUN, stall=1 with br_taken=1, br_target=32'h3100 for 2 cycles, then stall=0 -> pend=1 during stall, pc_en=0; release cycle npc=32'h3100, pc_en=1; pend=0 next cycle.
REQ-040 PEND with stall=1, exc_req=1 -> npc=32'h4180, pc_en=1, flush=1; next cycle pend=0, and stall release yields pc+4, not old target.
REQ-041 Same cycle exc_req=1, eret=1, jmp=1, epc=32'h3050 -> npc=32'h4180; drop exc_req -> npc=32'h3050, flush=1.
REQ-042 pc=32'h3002, then 32'h7000, then 32'h2FFC -> fetch_adel=1 each; pc=32'h6FFC -> fetch_adel=0; pc=32'hFFFFFFFC with no redirect -> npc=32'h00000000.
REQ-043 jmp=1 and br_taken=1, stall=0, jmp_target=32'h3200, br_target=32'h3300 -> npc=32'h3200.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer
// Chooses the next fetch address for the PC register each cycle. It ranks
// the redirect sources (exception entry, eret return, jump/branch) ahead of
// the freeze requested by the hazard unit. A redirect that arrives while
// the front end is frozen is held in pend_target. It is issued on the first
// unstalled cycle afterwards.
//
// Parameters
//   RESET_PC   fetch address presented while reset is asserted
//   EXC_ENTRY  exception / interrupt handler entry address
//   IMEM_LO    lowest legal fetch address
//   IMEM_HI    highest legal fetch address
//
// Ports
//   clk         clock, rising edge
//   reset       synchronous, active-high reset
//   pc          current fetch address from the PC register
//   stall       hazard unit freeze request for IF/ID
//   br_taken    branch resolved taken in ID
//   br_target   branch target
//   jmp         jump (j/jal/jr/jalr) in ID
//   jmp_target  jump target
//   exc_req     CP0 exception/interrupt acceptance
//   eret        eret committed
//   epc         CP0 EPC value
//   npc         next PC value to the PC register
//   pc_en       PC register write enable
//   flush       flush IF/ID and younger stages this cycle
//   fetch_adel  fetch address error flag for the current pc
//   pend        a redirect is latched and waiting (registered)
module pc_sequencer #(
   parameter logic [31:0] RESET_PC  = 32'h0000_3000,
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
   parameter logic [31:0] IMEM_LO   = 32'h0000_3000,
   parameter logic [31:0] IMEM_HI   = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        stall,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   input  logic        jmp,
   input  logic [31:0] jmp_target,
   input  logic        exc_req,
   input  logic        eret,
   input  logic [31:0] epc,
   output logic [31:0] npc,
   output logic        pc_en,
   output logic        flush,
   output logic        fetch_adel,
   output logic        pend
);

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t      state;
   logic [31:0] pend_target;
   logic [31:0] redirect_target;

   // A jump wins over a branch when both fire in the same cycle. The same
   // selection feeds the direct redirect and the value latched while stalled.
   always_comb begin
      redirect_target = br_target;
      if (jmp) begin
         redirect_target = jmp_target;
      end
   end

   // Next-PC selection. The cases are listed in priority order: reset,
   // exception, eret, then the pending or new redirect, then the stall
   // freeze, and last the sequential pc+4. Only an exception or an eret
   // throws away the younger instructions. An ordinary jump or branch
   // leaves the IF/ID contents alone.
   always_comb begin
      npc   = pc + 32'd4;
      pc_en = 1'b1;
      flush = 1'b0;
      if (reset) begin
         npc = RESET_PC;
      end else if (exc_req) begin
         npc   = EXC_ENTRY;
         flush = 1'b1;
      end else if (eret) begin
         npc   = epc;
         flush = 1'b1;
      end else if (state == PEND) begin
         if (stall) begin
            npc   = pc;
            pc_en = 1'b0;
         end else begin
            npc = pend_target;
         end
      end else if (stall) begin
         npc   = pc;
         pc_en = 1'b0;
      end else if (jmp || br_taken) begin
         npc = redirect_target;
      end
   end

   // The address error flag only reports the fault. It does not change
   // sequencing. It stays live during reset.
   always_comb begin
      fetch_adel = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);
   end

   // State and pending-target bookkeeping. The FSM enters PEND only when a
   // redirect arrives during a stall in RUN. While in PEND, any new
   // redirect is ignored until the held target has been issued. Reset,
   // exception and eret all return to RUN and drop whatever was waiting.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         pend_target <= 32'd0;
      end else if (exc_req || eret) begin
         state       <= RUN;
         pend_target <= 32'd0;
      end else if (state == RUN) begin
         if (stall && (jmp || br_taken)) begin
            state       <= PEND;
            pend_target <= redirect_target;
         end
      end else if (!stall) begin
         state <= RUN;
      end
   end

   assign pend = (state == PEND);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. A table of directed vectors covers
// the reset, stall/pending, exception and address-range corner cases. A
// randomized phase then follows, and its expectations come from a small
// priority-rule model that holds waiting redirects in a queue.
module tb_pc_sequencer;

   localparam logic [31:0] RESET_PC  = 32'h0000_3000;
   localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
   localparam logic [31:0] IMEM_LO   = 32'h0000_3000;
   localparam logic [31:0] IMEM_HI   = 32'h0000_6FFC;

   logic        clk;
   logic        reset;
   logic [31:0] pc;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        jmp;
   logic [31:0] jmp_target;
   logic        exc_req;
   logic        eret;
   logic [31:0] epc;
   logic [31:0] npc;
   logic        pc_en;
   logic        flush;
   logic        fetch_adel;
   logic        pend;

   int tests_run;
   int tests_failed;

   typedef struct {
      string       name;
      logic        rst;
      logic [31:0] pc;
      logic        stall;
      logic        br;
      logic [31:0] brt;
      logic        jmp;
      logic [31:0] jt;
      logic        exc;
      logic        eret;
      logic [31:0] epc;
      logic [31:0] e_npc;
      logic        e_pc_en;
      logic        e_flush;
      logic        e_adel;
      logic        e_pend;
      logic        chk_pend;
   } vec_t;

   vec_t vecs[$];

   // Redirects the model is still holding; at most one entry at a time
   logic [31:0] model_q[$];

   pc_sequencer #(
      .RESET_PC  (RESET_PC),
      .EXC_ENTRY (EXC_ENTRY),
      .IMEM_LO   (IMEM_LO),
      .IMEM_HI   (IMEM_HI)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .stall      (stall),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .jmp        (jmp),
      .jmp_target (jmp_target),
      .exc_req    (exc_req),
      .eret       (eret),
      .epc        (epc),
      .npc        (npc),
      .pc_en      (pc_en),
      .flush      (flush),
      .fetch_adel (fetch_adel),
      .pend       (pend)
   );

   // Free-running clock, 10 time units per period
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Builds one directed vector from its inputs and expected outputs
   function automatic vec_t mk(string name, logic rst, logic [31:0] p, logic st,
                               logic br, logic [31:0] brt, logic j, logic [31:0] jt,
                               logic ex, logic er, logic [31:0] ep,
                               logic [31:0] e_npc, logic e_en, logic e_fl,
                               logic e_adel, logic e_pend, logic chk_pend);
      vec_t v;
      v.name = name; v.rst = rst; v.pc = p; v.stall = st; v.br = br; v.brt = brt;
      v.jmp = j; v.jt = jt; v.exc = ex; v.eret = er; v.epc = ep;
      v.e_npc = e_npc; v.e_pc_en = e_en; v.e_flush = e_fl; v.e_adel = e_adel;
      v.e_pend = e_pend; v.chk_pend = chk_pend;
      return v;
   endfunction

   // Drives one cycle's worth of inputs just after the rising edge
   task automatic applyStimulus(input logic rst, input logic [31:0] p, input logic st,
                                input logic br, input logic [31:0] brt,
                                input logic j, input logic [31:0] jt,
                                input logic ex, input logic er, input logic [31:0] ep);
      @(posedge clk);
      #1;
      reset = rst; pc = p; stall = st; br_taken = br; br_target = brt;
      jmp = j; jmp_target = jt; exc_req = ex; eret = er; epc = ep;
   endtask

   // Samples the outputs on the falling edge and compares each field
   task automatic checkOutput(input string name, input logic [31:0] e_npc,
                              input logic e_en, input logic e_fl, input logic e_adel,
                              input logic e_pend, input logic chk_pend);
      @(negedge clk);
      tests_run++;
      if (npc !== e_npc) begin
         tests_failed++;
         $display("[TB] FAIL %s npc got %h expected %h", name, npc, e_npc);
      end
      tests_run++;
      if (pc_en !== e_en) begin
         tests_failed++;
         $display("[TB] FAIL %s pc_en got %b expected %b", name, pc_en, e_en);
      end
      tests_run++;
      if (flush !== e_fl) begin
         tests_failed++;
         $display("[TB] FAIL %s flush got %b expected %b", name, flush, e_fl);
      end
      tests_run++;
      if (fetch_adel !== e_adel) begin
         tests_failed++;
         $display("[TB] FAIL %s fetch_adel got %b expected %b", name, fetch_adel, e_adel);
      end
      if (chk_pend) begin
         tests_run++;
         if (pend !== e_pend) begin
            tests_failed++;
            $display("[TB] FAIL %s pend got %b expected %b", name, pend, e_pend);
         end
      end
   endtask

   // Address legality, written directly from the legal-window definition
   function automatic logic adel_of(logic [31:0] p);
      return (p % 4 != 0) || (p < IMEM_LO) || (p > IMEM_HI);
   endfunction

   initial begin
      tests_run = 0;
      tests_failed = 0;
      reset = 1'b1; pc = 32'h3000; stall = 1'b0; br_taken = 1'b0; br_target = '0;
      jmp = 1'b0; jmp_target = '0; exc_req = 1'b0; eret = 1'b0; epc = '0;

      // Directed vectors:
      // name, rst, pc, stall, br, brt, jmp, jt, exc, eret, epc,
      // npc, pc_en, flush, adel, pend, chk_pend
      vecs.push_back(mk("rst0",   1, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3000, 1, 0, 0, 0, 0));
      vecs.push_back(mk("rst1",   1, 32'h3000, 1, 1, 32'h3100, 1, 32'h3200, 1, 1, 32'h3050, 32'h3000, 1, 0, 0, 0, 1));
      vecs.push_back(mk("idle0",  0, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 1, 0, 0, 0, 1));
      vecs.push_back(mk("idle1",  0, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 1, 0, 0, 0, 1));
      vecs.push_back(mk("idle2",  0, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 1, 0, 0, 0, 1));
      // branch taken under stall, released later
      vecs.push_back(mk("bstl0",  0, 32'h3004, 1, 1, 32'h3100, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0, 0, 1));
      vecs.push_back(mk("bstl1",  0, 32'h3004, 1, 1, 32'h3100, 0, 0, 0, 0, 0, 32'h3004, 0, 0, 0, 1, 1));
      vecs.push_back(mk("brel",   0, 32'h3004, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3100, 1, 0, 0, 1, 1));
      vecs.push_back(mk("bpost",  0, 32'h3100, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3104, 1, 0, 0, 0, 1));
      // exception while a redirect is pending
      vecs.push_back(mk("estl0",  0, 32'h3104, 1, 0, 0, 1, 32'h3200, 0, 0, 0, 32'h3104, 0, 0, 0, 0, 1));
      vecs.push_back(mk("eexc",   0, 32'h3104, 1, 0, 0, 0, 0, 1, 0, 0, 32'h4180, 1, 1, 0, 1, 1));
      vecs.push_back(mk("estl1",  0, 32'h4180, 1, 0, 0, 0, 0, 0, 0, 0, 32'h4180, 0, 0, 0, 0, 1));
      vecs.push_back(mk("erel",   0, 32'h4180, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4184, 1, 0, 0, 0, 1));
      // exception beats eret beats jump
      vecs.push_back(mk("prio0",  0, 32'h4184, 0, 0, 0, 1, 32'h3200, 1, 1, 32'h3050, 32'h4180, 1, 1, 0, 0, 1));
      vecs.push_back(mk("eret",   0, 32'h4184, 0, 0, 0, 1, 32'h3200, 0, 1, 32'h3050, 32'h3050, 1, 1, 0, 0, 1));
      vecs.push_back(mk("reti",   0, 32'h3050, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3054, 1, 0, 0, 0, 1));
      // address range and wrap
      vecs.push_back(mk("unal",   0, 32'h3002, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3006, 1, 0, 1, 0, 1));
      vecs.push_back(mk("hi",     0, 32'h7000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7004, 1, 0, 1, 0, 1));
      vecs.push_back(mk("lo",     0, 32'h2FFC, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3000, 1, 0, 1, 0, 1));
      vecs.push_back(mk("top",    0, 32'h6FFC, 0, 0, 0, 0, 0, 0, 0, 0, 32'h7000, 1, 0, 0, 0, 1));
      vecs.push_back(mk("wrap",   0, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0000, 1, 0, 1, 0, 1));
      // jump beats branch
      vecs.push_back(mk("jvb",    0, 32'h3000, 0, 1, 32'h3300, 1, 32'h3200, 0, 0, 0, 32'h3200, 1, 0, 0, 0, 1));
      // PEND ignores new redirects
      vecs.push_back(mk("pj0",    0, 32'h3000, 1, 0, 0, 1, 32'h3200, 0, 0, 0, 32'h3000, 0, 0, 0, 0, 1));
      vecs.push_back(mk("pj1",    0, 32'h3000, 1, 1, 32'h3300, 0, 0, 0, 0, 0, 32'h3000, 0, 0, 0, 1, 1));
      vecs.push_back(mk("pjrel",  0, 32'h3000, 0, 0, 0, 1, 32'h3400, 0, 0, 0, 32'h3200, 1, 0, 0, 1, 1));
      vecs.push_back(mk("pjpost", 0, 32'h3200, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3204, 1, 0, 0, 0, 1));
      // reset in PEND drops the target
      vecs.push_back(mk("rp0",    0, 32'h3000, 1, 1, 32'h3300, 0, 0, 0, 0, 0, 32'h3000, 0, 0, 0, 0, 1));
      vecs.push_back(mk("rp1",    1, 32'h3010, 1, 1, 32'h3300, 0, 0, 0, 0, 0, 32'h3000, 1, 0, 0, 1, 1));
      vecs.push_back(mk("rp2",    0, 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 32'h3004, 1, 0, 0, 0, 1));

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].pc, vecs[i].stall, vecs[i].br, vecs[i].brt,
                       vecs[i].jmp, vecs[i].jt, vecs[i].exc, vecs[i].eret, vecs[i].epc);
         checkOutput(vecs[i].name, vecs[i].e_npc, vecs[i].e_pc_en, vecs[i].e_flush,
                     vecs[i].e_adel, vecs[i].e_pend, vecs[i].chk_pend);
      end

      // Randomized phase: the DUT is in RUN with nothing held after rp2
      model_q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         logic        r_rst, r_st, r_br, r_j, r_ex, r_er;
         logic [31:0] r_pc, r_brt, r_jt, r_ep;
         logic [31:0] e_npc;
         logic        e_en, e_fl, e_pend;
         r_rst = ($urandom_range(0, 49) == 0);
         r_st  = ($urandom_range(0, 2) == 0);
         r_br  = ($urandom_range(0, 3) == 0);
         r_j   = ($urandom_range(0, 4) == 0);
         r_ex  = ($urandom_range(0, 24) == 0);
         r_er  = ($urandom_range(0, 19) == 0);
         r_pc  = ($urandom_range(0, 7) == 0) ? $urandom : (32'h3000 + ($urandom_range(0, 4095) * 4));
         r_brt = 32'h3000 + $urandom_range(0, 4095) * 4;
         r_jt  = 32'h3000 + $urandom_range(0, 4095) * 4;
         r_ep  = $urandom;

         e_pend = (model_q.size() > 0);
         e_fl   = 1'b0;
         e_en   = 1'b1;
         if (r_rst) begin
            e_npc = RESET_PC;
            model_q.delete();
         end else if (r_ex) begin
            e_npc = EXC_ENTRY;
            e_fl  = 1'b1;
            model_q.delete();
         end else if (r_er) begin
            e_npc = r_ep;
            e_fl  = 1'b1;
            model_q.delete();
         end else if (model_q.size() > 0) begin
            if (r_st) begin
               e_npc = r_pc;
               e_en  = 1'b0;
            end else begin
               e_npc = model_q.pop_front();
            end
         end else if (r_st) begin
            e_npc = r_pc;
            e_en  = 1'b0;
            if (r_j) model_q.push_back(r_jt);
            else if (r_br) model_q.push_back(r_brt);
         end else if (r_j) begin
            e_npc = r_jt;
         end else if (r_br) begin
            e_npc = r_brt;
         end else begin
            e_npc = r_pc + 32'd4;
         end

         applyStimulus(r_rst, r_pc, r_st, r_br, r_brt, r_j, r_jt, r_ex, r_er, r_ep);
         checkOutput($sformatf("rand%0d", cyc), e_npc, e_en, e_fl, adel_of(r_pc), e_pend, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
